// File: rtl/display_digit_mux_pkg.sv
// Shared definitions for the timer display path.
//   - Seven-segment patterns, active-high, bit order {g,f,e,d,c,b,a}.
//   - Segment bit positions on the 8-bit bus (dp on top).
//   - Shadow register layout and a one-hot helper.
package display_digit_mux_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4;
  localparam int SEG_W      = 7;

  // Bit positions on the segment bus; segments[SEG_DP] is the decimal point.
  typedef enum int {
    SEG_A  = 0,
    SEG_B  = 1,
    SEG_C  = 2,
    SEG_D  = 3,
    SEG_E  = 4,
    SEG_F  = 5,
    SEG_G  = 6,
    SEG_DP = 7
  } seg_bit_e;

  localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
  localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][BCD_W-1:0] digit;
    logic [NUM_DIGITS-1:0]            dp;
  } shadow_t;

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/display_digit_mux_bcd_to_seven_segment.sv
// BCD to seven-segment decoder, purely combinational.
//   bcd_i : 4-bit BCD value
//   seg_o : active-high pattern {g,f,e,d,c,b,a}; 10..15 show a dash
module bcd_to_seven_segment
  import display_digit_mux_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_digit_mux.sv
// Multiplexed four-digit seven-segment driver.
//   clock/reset  : rising-edge clock, async active-low reset
//   displays     : one-hot digit enable from the selector ring (bit3 = leftmost)
//   digits       : four BCD digits, [15:12] = leftmost
//   dp_mask      : decimal point per digit
//   load         : capture digits/dp_mask into the shadow
//   lz_blank     : suppress leading zeros
//   segments     : {dp,g,f,e,d,c,b,a}, registered
//   anodes       : per-digit drive, registered
//   select_fault : displays not one-hot, registered
// Blanks all anodes for BLANK_CYCLES+1 cycles after each selector change to
// avoid ghosting while the previous digit's drivers discharge.
module display_digit_mux
  import display_digit_mux_pkg::*;
#(
  parameter int BLANK_CYCLES = 2,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_DIGITS-1:0]       displays,
  input  logic [NUM_DIGITS*BCD_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]       dp_mask,
  input  logic                        load,
  input  logic                        lz_blank,
  output logic [SEG_W:0]              segments,
  output logic [NUM_DIGITS-1:0]       anodes,
  output logic                        select_fault
);

  localparam int CNT_W = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);

  shadow_t                    shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]      prev_sel_q;
  logic [CNT_W-1:0]           blank_cnt_q, blank_cnt_d;
  logic [SEG_W:0]             segments_q, segments_d;
  logic [NUM_DIGITS-1:0]      anodes_q, anodes_d;
  logic                       fault_q, fault_d;

  logic                       changed, blanking, onehot;
  logic [NUM_DIGITS-1:0]      lz_digit;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] pat;
  logic [NUM_DIGITS-1:0][SEG_W:0]   lane_seg;

  // ---------------- per-digit decode ----------------
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    bcd_to_seven_segment u_dec (
      .bcd_i (shadow_q.digit[g]),
      .seg_o (pat[g])
    );
    // Blanked digits keep their dp so e.g. "  .5" still shows the point.
    assign lane_seg[g] = {shadow_q.dp[g], lz_digit[g] ? SEG_OFF : pat[g]};
  end

  // Digit n is a leading zero only if it and every digit left of it are 0.
  always_comb begin
    logic zeros;
    lz_digit = '0;
    zeros    = lz_blank;
    for (int n = NUM_DIGITS - 1; n >= 1; n--) begin
      zeros       = zeros && (shadow_q.digit[n] == '0);
      lz_digit[n] = zeros;
    end
  end

  // ---------------- change detect / blank counter ----------------
  assign onehot  = is_onehot(displays);
  assign changed = (displays != prev_sel_q);

  always_comb begin
    blank_cnt_d = blank_cnt_q;
    if (changed)                blank_cnt_d = BLANK_LOAD;
    else if (blank_cnt_q != '0) blank_cnt_d = blank_cnt_q - CNT_W'(1);
  end

  // Dark on the change edge plus BLANK_CYCLES edges after it, giving
  // BLANK_CYCLES+1 inactive output cycles per change.
  assign blanking = changed || (blank_cnt_q != '0);

  assign shadow_d = load ? shadow_t'{digit: digits, dp: dp_mask} : shadow_q;

  // ---------------- output select (active-high) ----------------
  always_comb begin
    segments_d = '0;
    anodes_d   = '0;
    fault_d    = 1'b0;
    if (!onehot) begin
      fault_d = 1'b1;
    end else if (!blanking) begin
      anodes_d = displays;
      for (int n = 0; n < NUM_DIGITS; n++)
        if (displays[n]) segments_d = segments_d | lane_seg[n];
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow_q    <= '0;
      prev_sel_q  <= '0;
      blank_cnt_q <= '0;
      segments_q  <= {(SEG_W+1){ACTIVE_LOW}};
      anodes_q    <= {NUM_DIGITS{ACTIVE_LOW}};
      fault_q     <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      prev_sel_q  <= displays;
      blank_cnt_q <= blank_cnt_d;
      // Polarity applied only here; everything upstream is active-high.
      segments_q  <= ACTIVE_LOW ? ~segments_d : segments_d;
      anodes_q    <= ACTIVE_LOW ? ~anodes_d   : anodes_d;
      fault_q     <= fault_d;
    end
  end

  assign segments     = segments_q;
  assign anodes       = anodes_q;
  assign select_fault = fault_q;

endmodule
